// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default geometry for the programmable-threshold FIFO.
package fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    // Pointer width: enough bits to address entries 0..depth-1.
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Count/threshold width: enough bits to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_DEPTH,
    localparam int PW = ptr_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PW-1:0]         wr_addr,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    input  logic [PW-1:0]         rd_addr,
    output logic [FIFO_WIDTH-1:0] rd_data
);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty levels and status pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_DEPTH,
    localparam int CW = cnt_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);

    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [FIFO_WIDTH-1:0] rd_data;

    // Explicit wrap so non-power-of-two depths never walk off the array.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign almostfull  = (count >= af_thresh) && !full;
    assign almostempty = (count <= ae_thresh) && !empty;
    assign wr_acc      = wr_en && !full;
    assign rd_acc      = rd_en && !empty;

    fifo_mem #(
        .FIFO_WIDTH(FIFO_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_acc),
        .wr_addr(wr_ptr),
        .wr_data(data_in),
        .rd_addr(rd_ptr),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
            if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown directly; gated to zero while nothing valid is stored.
    assign data_out = empty ? '0 : rd_data;
    assign rd_valid = !empty;
`else
    logic [FIFO_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) data_q <= rd_data;
        end
    end

    assign data_out = data_q;
    assign rd_valid = valid_q;
`endif

    a_wr_acc:  assert property (@(posedge clk) disable iff (!rst_n) wr_acc |-> !full);
    a_rd_acc:  assert property (@(posedge clk) disable iff (!rst_n) rd_acc |-> !empty);
    a_ack_on:  assert property (@(posedge clk) disable iff (!rst_n) wr_acc |=> wr_ack);
    a_ack_off: assert property (@(posedge clk) disable iff (!rst_n) !wr_acc |=> !wr_ack);
    a_ovf_on:  assert property (@(posedge clk) disable iff (!rst_n) (wr_en && full) |=> overflow);
    a_ovf_off: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full) |=> !overflow);
    a_udf_on:  assert property (@(posedge clk) disable iff (!rst_n) (rd_en && empty) |=> underflow);
    a_udf_off: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty) |=> !underflow);
    a_cnt_inc: assert property (@(posedge clk) disable iff (!rst_n)
                   (wr_acc && !rd_acc) |=> count == $past(count) + CW'(1));
    a_cnt_dec: assert property (@(posedge clk) disable iff (!rst_n)
                   (!wr_acc && rd_acc) |=> count == $past(count) - CW'(1));
    a_cnt_hld: assert property (@(posedge clk) disable iff (!rst_n)
                   (wr_acc == rd_acc) |=> count == $past(count));
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_CNT);
    a_wr_wrap: assert property (@(posedge clk) disable iff (!rst_n)
                   wr_acc |=> wr_ptr == next_ptr($past(wr_ptr)));
    a_rd_wrap: assert property (@(posedge clk) disable iff (!rst_n)
                   rd_acc |=> rd_ptr == next_ptr($past(rd_ptr)));
    a_flags:   assert property (@(posedge clk) disable iff (!rst_n)
                   (full == (count == DEPTH_CNT)) && (empty == (count == '0)));
    a_almost:  assert property (@(posedge clk) disable iff (!rst_n)
                   (almostfull == ((count >= af_thresh) && !full)) &&
                   (almostempty == ((count <= ae_thresh) && !empty)));

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Randomized bench for sync_fifo_prog: depth-8 and depth-6 instances against a queue model.
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       wr_en, rd_en;
    logic [1:0][15:0] data_in, data_out;
    logic [1:0]       rd_valid, wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    logic [3:0]       count_a, af_a, ae_a;
    logic [2:0]       count_b, af_b, ae_b;
    int               th_af, th_ae;

    assign af_a = 4'(th_af);
    assign ae_a = 4'(th_ae);
    assign af_b = 3'(th_af);
    assign ae_b = 3'(th_ae);

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .data_in(data_in[0]), .rd_en(rd_en[0]),
        .af_thresh(af_a), .ae_thresh(ae_a), .data_out(data_out[0]), .rd_valid(rd_valid[0]),
        .wr_ack(wr_ack[0]), .overflow(overflow[0]), .underflow(underflow[0]), .full(full[0]),
        .empty(empty[0]), .almostfull(almostfull[0]), .almostempty(almostempty[0]), .count(count_a)
    );

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .data_in(data_in[1]), .rd_en(rd_en[1]),
        .af_thresh(af_b), .ae_thresh(ae_b), .data_out(data_out[1]), .rd_valid(rd_valid[1]),
        .wr_ack(wr_ack[1]), .overflow(overflow[1]), .underflow(underflow[1]), .full(full[1]),
        .empty(empty[1]), .almostfull(almostfull[1]), .almostempty(almostempty[1]), .count(count_b)
    );

    // Reference model: contents as a queue plus last-cycle status expectations.
    logic [15:0] q[$];
    logic [15:0] e_dout;
    bit          e_ack, e_ovf, e_udf, e_rv;
    int          sel;
    int          n_chk, n_pass;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s [dut%0d] got 0x%0h expected 0x%0h", tag, sel, obs, exp);
    endtask

    task automatic check_all();
        int d   = (sel != 0) ? 6 : 8;
        int c   = q.size();
        int cnt = (sel != 0) ? int'(count_b) : int'(count_a);
        chk("count", cnt, c);
        chk("full", int'(full[sel]), int'(c == d));
        chk("empty", int'(empty[sel]), int'(c == 0));
        chk("almostfull", int'(almostfull[sel]), int'(c >= th_af && c != d));
        chk("almostempty", int'(almostempty[sel]), int'(c <= th_ae && c != 0));
        chk("wr_ack", int'(wr_ack[sel]), int'(e_ack));
        chk("overflow", int'(overflow[sel]), int'(e_ovf));
        chk("underflow", int'(underflow[sel]), int'(e_udf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("rd_valid", int'(rd_valid[sel]), int'(c != 0));
        chk("data_out", int'(data_out[sel]), (c != 0) ? int'(q[0]) : 0);
`else
        chk("rd_valid", int'(rd_valid[sel]), int'(e_rv));
        chk("data_out", int'(data_out[sel]), int'(e_dout));
`endif
    endtask

    task automatic cycle(input bit we, input bit re, input logic [15:0] din);
        int d = (sel != 0) ? 6 : 8;
        bit was_full, was_empty;
        wr_en        = '0;
        rd_en        = '0;
        wr_en[sel]   = we;
        rd_en[sel]   = re;
        data_in[sel] = din;
        @(posedge clk);
        was_full  = (q.size() == d);
        was_empty = (q.size() == 0);
        e_ack = we && !was_full;
        e_ovf = we && was_full;
        e_udf = re && was_empty;
        e_rv  = re && !was_empty;
        if (e_rv) e_dout = q.pop_front();
        if (e_ack) q.push_back(din);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        e_dout = '0;
        e_ack  = 1'b0;
        e_ovf  = 1'b0;
        e_udf  = 1'b0;
        e_rv   = 1'b0;
        #1;
        check_all();
        wr_en = '0;
        rd_en = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_run(input int cycles, input int wr_pct, input int rd_pct, input int th_max);
        for (int i = 0; i < cycles; i++) begin
            if (i % 16 == 0) begin
                th_af = $urandom_range(0, th_max);
                th_ae = $urandom_range(0, th_max);
            end
            cycle($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct,
                  16'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        sel     = 0;
        rst_n   = 1'b1;
        wr_en   = '0;
        rd_en   = '0;
        data_in = '0;
        th_af   = 6;
        th_ae   = 2;
        #2;
        do_reset();

        // Fill to full, overflow attempt, drain in order, then underflow.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 16'(i));
        cycle(1'b1, 1'b0, 16'hDEAD);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);

        // Reset in the middle of a write at occupancy five.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h0A00 + 16'(i));
        wr_en[0]   = 1'b1;
        data_in[0] = 16'h55AA;
        #1;
        do_reset();
        cycle(1'b1, 1'b0, 16'h1234);
        cycle(1'b0, 1'b1, 16'h0);

        random_run(80, 70, 30, 15);
        random_run(80, 30, 70, 15);
        random_run(80, 90, 20, 15);
        random_run(80, 50, 50, 15);

        // Depth-6 instance: hold three entries while streaming through the wrap point.
        sel   = 1;
        th_af = 4;
        th_ae = 1;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0B00 + 16'(i));
        for (int i = 3; i < 17; i++) cycle(1'b1, 1'b1, 16'h0B00 + 16'(i));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0);

        random_run(80, 70, 30, 7);
        random_run(80, 30, 70, 7);
        random_run(80, 50, 50, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 Parameter FIFO_WIDTH, default 16: data word width in bits, >=1.
REQ-002 Parameter FIFO_DEPTH, default 8: number of storage entries, any integer >=2, power of two not required.
REQ-003 Port clk  input  1: single clock, all state updates on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port wr_en  input  1: write request; data_in  input  FIFO_WIDTH: write data.
REQ-006 Port rd_en  input  1: read request (pop).
REQ-007 Port af_thresh / ae_thresh  input  CW each (CW = $clog2(FIFO_DEPTH+1)): programmable almost-full / almost-empty levels.
REQ-008 Port data_out  output  FIFO_WIDTH: read data; rd_valid  output  1: data_out carries a newly popped word.
REQ-009 Ports wr_ack, overflow, underflow  output  1 each: registered per-cycle status pulses.
REQ-010 Ports full, empty, almostfull, almostempty  output  1 each: combinational level flags.
REQ-011 Port count  output  CW: current occupancy, 0..FIFO_DEPTH.

Function
REQ-012 Write accepted iff wr_en && !full at the clock edge; stores data_in at wr_ptr.
REQ-013 Read accepted iff rd_en && !empty at the clock edge; pops entry at rd_ptr.
REQ-014 Simultaneous wr_en and rd_en: each is judged independently per REQ-012/013; at full only the read succeeds, at empty only the write succeeds.
REQ-015 count next = count + wr_acc - rd_acc; never exceeds FIFO_DEPTH, never below 0.
REQ-016 wr_ptr/rd_ptr advance by 1 per accepted op and wrap from FIFO_DEPTH-1 to 0 explicitly (no reliance on binary rollover).
REQ-017 wr_ack = 1 in the cycle after an accepted write, else 0.
REQ-018 overflow = 1 in the cycle after wr_en && full, else 0; underflow = 1 in the cycle after rd_en && empty, else 0.
REQ-019 full = (count == FIFO_DEPTH); empty = (count == 0).
REQ-020 almostfull = (count >= af_thresh) && !full; almostempty = (count <= ae_thresh) && !empty.
REQ-021 Threshold values outside 0..FIFO_DEPTH are legal; the comparisons of REQ-020 apply unchanged.
REQ-022 Standard mode: data_out loads mem[rd_ptr] one cycle after an accepted read; rd_valid pulses 1 for that cycle; data_out holds its value otherwise.
REQ-023 Memory contents are not cleared by reset; reading them is prevented by the empty flag.

Reset
REQ-024 rst_n low asynchronously forces wr_ptr=0, rd_ptr=0, count=0, wr_ack=0, overflow=0, underflow=0, rd_valid=0, data_out=0.
REQ-025 During reset: empty=1, full=0, almostfull=0, almostempty=0; reset mid-transfer discards all stored entries.
REQ-026 First accepted operation occurs on the first rising clk edge with rst_n high.

Configuration
REQ-027 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; data_out continuously shows mem[rd_ptr], rd_valid = !empty, an accepted read advances to the next word with zero-cycle latency.
REQ-028 Macro SYNC_FIFO_FWFT_EN undefined: standard registered-read behaviour of REQ-022.
REQ-029 All flag, count, ack and error behaviour is identical in both modes.

Structure
REQ-030 Package fifo_pkg holds the pointer/count width function (clog2 of depth and depth+1) and the default width/depth constants.
REQ-031 Storage is sub-module fifo_mem (synchronous write, asynchronous read array, FIFO_WIDTH x FIFO_DEPTH); control, pointers and flags stay in sync_fifo_prog.
REQ-032 The block carries concurrent assertions for REQ-012 through REQ-020, disabled while rst_n is low.

Verification
REQ-033 WIDTH=16, DEPTH=8, reset then 8 writes 0x0001..0x0008 -> full=1, count=8, wr_ack high on each of the 8 following cycles.
REQ-034 Full FIFO, wr_en=1 with data 0xDEAD -> overflow=1 next cycle, count stays 8, subsequent 8 reads return 0x0001..0x0008 in order.
REQ-035 Empty FIFO, rd_en=1 -> underflow=1 next cycle, rd_valid=0, count stays 0.
REQ-036 DEPTH=6 (non power of two), 20 interleaved writes/reads with simultaneous wr_en&rd_en at count=3 -> count stays 3, data order preserved across pointer wrap 5->0.
REQ-037 af_thresh=6, ae_thresh=2, fill 0..8 -> almostempty high at counts 1..2, almostfull high at counts 6..7, both low at 0 and 8.
REQ-038 rst_n pulsed low at count=5 mid-write -> all outputs per REQ-024/025 immediately, next write/read pair returns the new word; repeat with SYNC_FIFO_FWFT_EN defined and check zero-latency data_out.
